// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side next-PC predictor with a direct-mapped BTB
// and 2-bit saturating counters, resolved against execute-stage outcomes.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   f_pc           fetch PC to predict for
//   pred_taken     combinational prediction for f_pc
//   pred_target    predicted next PC (BTB target or f_pc+4)
//   r_valid        resolve strobe from execute
//   r_pc           PC of the resolving instruction
//   r_br_type      branch kind (2 = not a branch, 3 = jal/jalr)
//   r_br_taken     actual outcome
//   r_target       actual taken target
//   r_pred_taken   prediction carried with the instruction
//   r_pred_target  predicted next PC carried with the instruction
//   flush          registered one-cycle pulse per mispredict
//   redirect_pc    registered correct next PC, valid while flush=1
//   br_count       resolved branch count
//   mispred_count  mispredict count

module branch_predictor #(
    parameter int BUS_WIDTH = 32,
    parameter int ENTRIES   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] f_pc,
    output logic                 pred_taken,
    output logic [BUS_WIDTH-1:0] pred_target,
    input  logic                 r_valid,
    input  logic [BUS_WIDTH-1:0] r_pc,
    input  logic [2:0]           r_br_type,
    input  logic                 r_br_taken,
    input  logic [BUS_WIDTH-1:0] r_target,
    input  logic                 r_pred_taken,
    input  logic [BUS_WIDTH-1:0] r_pred_target,
    output logic                 flush,
    output logic [BUS_WIDTH-1:0] redirect_pc,
    output logic [31:0]          br_count,
    output logic [31:0]          mispred_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = BUS_WIDTH - IDX_W - 2;

    localparam logic [2:0] BR_NONE = 3'd2;
    localparam logic [2:0] BR_JAL  = 3'd3;

    localparam logic [BUS_WIDTH-1:0] PC_STEP = BUS_WIDTH'(4);

    // BTB storage
    logic                 r_vld [ENTRIES];
    logic [TAG_W-1:0]     r_tag [ENTRIES];
    logic [BUS_WIDTH-1:0] r_tgt [ENTRIES];
    logic [1:0]           r_ctr [ENTRIES];
    logic                 r_unc [ENTRIES];

    logic                 r_flush;
    logic [BUS_WIDTH-1:0] r_redirect;
    logic [31:0]          r_br_cnt;
    logic [31:0]          r_mis_cnt;

    // Fetch-side lookup
    logic [IDX_W-1:0]     w_f_idx;
    logic [TAG_W-1:0]     w_f_tag;
    logic                 w_f_hit;
    logic [BUS_WIDTH-1:0] w_f_pc4;

    assign w_f_idx = f_pc[IDX_W+1:2];
    assign w_f_tag = f_pc[BUS_WIDTH-1:IDX_W+2];
    assign w_f_hit = r_vld[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_f_pc4 = f_pc + PC_STEP;

    assign pred_taken  = w_f_hit && (r_unc[w_f_idx] || r_ctr[w_f_idx][1]);
    assign pred_target = pred_taken ? r_tgt[w_f_idx] : w_f_pc4;

    // Resolve-side lookup and mispredict detection
    logic [IDX_W-1:0]     w_r_idx;
    logic [TAG_W-1:0]     w_r_tag;
    logic                 w_r_hit;
    logic                 w_is_br;
    logic [BUS_WIDTH-1:0] w_r_pc4;
    logic [BUS_WIDTH-1:0] w_actual_next;
    logic [BUS_WIDTH-1:0] w_pred_next;
    logic                 w_mispredict;

    assign w_r_idx = r_pc[IDX_W+1:2];
    assign w_r_tag = r_pc[BUS_WIDTH-1:IDX_W+2];
    assign w_r_hit = r_vld[w_r_idx] && (r_tag[w_r_idx] == w_r_tag);
    assign w_is_br = (r_br_type != BR_NONE);
    assign w_r_pc4 = r_pc + PC_STEP;

    // A non-branch always falls through, whatever r_br_taken says
    assign w_actual_next = (w_is_br && r_br_taken) ? r_target : w_r_pc4;
    assign w_pred_next   = r_pred_taken ? r_pred_target : w_r_pc4;
    assign w_mispredict  = r_valid && (w_actual_next != w_pred_next);

    // Table update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_vld[i] <= 1'b0;
                r_tag[i] <= '0;
                r_tgt[i] <= '0;
                r_ctr[i] <= 2'd0;
                r_unc[i] <= 1'b0;
            end
        end else if (r_valid && w_is_br) begin
            if (w_r_hit) begin
                if (r_br_taken) begin
                    if (r_ctr[w_r_idx] != 2'd3)
                        r_ctr[w_r_idx] <= r_ctr[w_r_idx] + 2'd1;
                    r_tgt[w_r_idx] <= r_target;
                end else if (r_ctr[w_r_idx] != 2'd0) begin
                    r_ctr[w_r_idx] <= r_ctr[w_r_idx] - 2'd1;
                end
            end else if (r_br_taken) begin
                // Allocation overwrites whatever occupied the slot
                r_vld[w_r_idx] <= 1'b1;
                r_tag[w_r_idx] <= w_r_tag;
                r_tgt[w_r_idx] <= r_target;
                if (r_br_type == BR_JAL) begin
                    r_ctr[w_r_idx] <= 2'd3;
                    r_unc[w_r_idx] <= 1'b1;
                end else begin
                    r_ctr[w_r_idx] <= 2'd2;
                    r_unc[w_r_idx] <= 1'b0;
                end
            end
        end
    end

    // Redirect and statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush    <= 1'b0;
            r_redirect <= '0;
            r_br_cnt   <= '0;
            r_mis_cnt  <= '0;
        end else begin
            r_flush <= w_mispredict;
            if (w_mispredict)
                r_redirect <= w_actual_next;
            if (r_valid && w_is_br)
                r_br_cnt <= r_br_cnt + 32'd1;
            if (w_mispredict)
                r_mis_cnt <= r_mis_cnt + 32'd1;
        end
    end

    assign flush         = r_flush;
    assign redirect_pc   = r_redirect;
    assign br_count      = r_br_cnt;
    assign mispred_count = r_mis_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and randomised checks of branch_predictor.
// Each task drives one scenario and checks its own hand-computed results.

module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] f_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [2:0]  r_br_type;
    logic        r_br_taken;
    logic [31:0] r_target;
    logic        r_pred_taken;
    logic [31:0] r_pred_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int n_checks;
    int n_fail;

    logic [31:0] exp_br;
    logic [31:0] exp_mis;
    logic        last_mis;

    branch_predictor #(.BUS_WIDTH(32), .ENTRIES(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .f_pc          (f_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .r_valid       (r_valid),
        .r_pc          (r_pc),
        .r_br_type     (r_br_type),
        .r_br_taken    (r_br_taken),
        .r_target      (r_target),
        .r_pred_taken  (r_pred_taken),
        .r_pred_target (r_pred_target),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference for the resolve bookkeeping of one strobe
    task automatic model_resolve(input logic [31:0] pc, input logic [2:0] ty,
                                 input logic tk, input logic [31:0] tg,
                                 input logic ptk, input logic [31:0] ptg);
        logic [31:0] act;
        logic [31:0] prd;
        act = (ty != 3'd2 && tk) ? tg : pc + 32'd4;
        prd = ptk ? ptg : pc + 32'd4;
        last_mis = (act != prd);
        if (ty != 3'd2) exp_br = exp_br + 32'd1;
        if (last_mis) exp_mis = exp_mis + 32'd1;
    endtask

    // One resolve strobe; returns #1 after the capturing edge
    task automatic resolve(input logic [31:0] pc, input logic [2:0] ty,
                           input logic tk, input logic [31:0] tg,
                           input logic ptk, input logic [31:0] ptg);
        @(negedge clk);
        r_valid       = 1'b1;
        r_pc          = pc;
        r_br_type     = ty;
        r_br_taken    = tk;
        r_target      = tg;
        r_pred_taken  = ptk;
        r_pred_target = ptg;
        model_resolve(pc, ty, tk, tg, ptk, ptg);
        @(posedge clk);
        #1;
        r_valid = 1'b0;
    endtask

    task automatic test_reset();
        f_pc = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (flush !== 1'b0 || redirect_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_flush: flush=%b redirect=%h want 0/0", flush, redirect_pc);
        end
        n_checks++;
        if (br_count !== 32'd0 || mispred_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counts: br=%0d mis=%0d want 0/0", br_count, mispred_count);
        end
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++;
            $display("FAIL reset_pred: taken=%b tgt=%h want 0/104", pred_taken, pred_target);
        end
        @(negedge clk);
        rst = 1'b0;
        resolve(32'h100, 3'd0, 1'b1, 32'h80, 1'b0, 32'h0);
        n_checks++;
        if (flush !== 1'b1 || br_count !== 32'd1) begin
            n_fail++;
            $display("FAIL pre_async: flush=%b br=%0d want 1/1", flush, br_count);
        end
        // Async reset in the middle of the high phase
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (flush !== 1'b0 || redirect_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL async_flush: flush=%b redirect=%h want 0/0", flush, redirect_pc);
        end
        n_checks++;
        if (br_count !== 32'd0 || mispred_count !== 32'd0) begin
            n_fail++;
            $display("FAIL async_counts: br=%0d mis=%0d want 0/0", br_count, mispred_count);
        end
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++;
            $display("FAIL async_pred: taken=%b tgt=%h want 0/104", pred_taken, pred_target);
        end
        // A resolve strobe while reset is held must be ignored
        @(negedge clk);
        r_valid      = 1'b1;
        r_pc         = 32'h100;
        r_br_type    = 3'd0;
        r_br_taken   = 1'b1;
        r_target     = 32'h80;
        r_pred_taken = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (br_count !== 32'd0 || flush !== 1'b0 || pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ignore: br=%0d flush=%b pt=%b want 0/0/0",
                     br_count, flush, pred_taken);
        end
        @(negedge clk);
        r_valid = 1'b0;
        rst     = 1'b0;
        exp_br  = 32'd0;
        exp_mis = 32'd0;
    endtask

    task automatic test_cold_loop();
        resolve(32'h100, 3'd0, 1'b1, 32'h80, 1'b0, 32'h0);
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h80) begin
            n_fail++;
            $display("FAIL cold_flush: flush=%b redirect=%h want 1/80", flush, redirect_pc);
        end
        f_pc = 32'h100;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_fail++;
            $display("FAIL cold_pred: taken=%b tgt=%h want 1/80", pred_taken, pred_target);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (flush !== 1'b0 || redirect_pc !== 32'h80) begin
            n_fail++;
            $display("FAIL cold_pulse: flush=%b redirect=%h want 0/80", flush, redirect_pc);
        end
    endtask

    task automatic test_saturation();
        resolve(32'h100, 3'd0, 1'b0, 32'h80, 1'b1, 32'h80);
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h104) begin
            n_fail++;
            $display("FAIL sat_first: flush=%b redirect=%h want 1/104", flush, redirect_pc);
        end
        for (int k = 0; k < 3; k++) begin
            resolve(32'h100, 3'd0, 1'b0, 32'h80, 1'b0, 32'h0);
            n_checks++;
            if (flush !== 1'b0 || redirect_pc !== 32'h104) begin
                n_fail++;
                $display("FAIL sat_nt%0d: flush=%b redirect=%h want 0/104",
                         k, flush, redirect_pc);
            end
        end
        f_pc = 32'h100;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++;
            $display("FAIL sat_low: taken=%b tgt=%h want 0/104", pred_taken, pred_target);
        end
        // 0 -> 1 -> 2 -> 3 -> 3, then one not-taken leaves 2 (still taken)
        for (int k = 0; k < 4; k++)
            resolve(32'h100, 3'd0, 1'b1, 32'h80, 1'b0, 32'h0);
        resolve(32'h100, 3'd0, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_fail++;
            $display("FAIL sat_high: taken=%b tgt=%h want 1/80", pred_taken, pred_target);
        end
    endtask

    task automatic test_jal();
        resolve(32'h200, 3'd3, 1'b1, 32'h400, 1'b0, 32'h0);
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h400) begin
            n_fail++;
            $display("FAIL jal_alloc: flush=%b redirect=%h want 1/400", flush, redirect_pc);
        end
        for (int k = 0; k < 10; k++)
            resolve(32'h300 + 32'(4 * k), 3'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++;
        if (flush !== 1'b0) begin
            n_fail++;
            $display("FAIL jal_others: flush=%b want 0", flush);
        end
        f_pc = 32'h200;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin
            n_fail++;
            $display("FAIL jal_pred: taken=%b tgt=%h want 1/400", pred_taken, pred_target);
        end
        resolve(32'h200, 3'd2, 1'b0, 32'h0, 1'b1, 32'h400);
        n_checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h204) begin
            n_fail++;
            $display("FAIL nojump_flush: flush=%b redirect=%h want 1/204", flush, redirect_pc);
        end
        n_checks++;
        if (br_count !== exp_br || mispred_count !== exp_mis) begin
            n_fail++;
            $display("FAIL nojump_counts: br=%0d mis=%0d want %0d/%0d",
                     br_count, mispred_count, exp_br, exp_mis);
        end
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin
            n_fail++;
            $display("FAIL nojump_entry: taken=%b tgt=%h want 1/400", pred_taken, pred_target);
        end
    endtask

    // Also covers back-to-back flush pulses
    task automatic test_alias();
        logic [31:0] pc;
        logic [31:0] tg;
        for (int k = 0; k < 4; k++) begin
            pc = (k % 2 == 0) ? 32'h100 : 32'h140;
            tg = (k % 2 == 0) ? 32'h80 : 32'h180;
            f_pc = pc;
            #1;
            n_checks++;
            if (pred_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL alias_miss%0d: taken=%b want 0", k, pred_taken);
            end
            resolve(pc, 3'd0, 1'b1, tg, 1'b0, 32'h0);
            n_checks++;
            if (flush !== 1'b1 || redirect_pc !== tg) begin
                n_fail++;
                $display("FAIL alias_flush%0d: flush=%b redirect=%h want 1/%h",
                         k, flush, redirect_pc, tg);
            end
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        f_pc          = 32'h100;
        r_valid       = 1'b1;
        r_pc          = 32'h100;
        r_br_type     = 3'd0;
        r_br_taken    = 1'b1;
        r_target      = 32'h80;
        r_pred_taken  = 1'b0;
        r_pred_target = 32'h0;
        model_resolve(32'h100, 3'd0, 1'b1, 32'h80, 1'b0, 32'h0);
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++;
            $display("FAIL same_old: taken=%b tgt=%h want 0/104", pred_taken, pred_target);
        end
        @(posedge clk);
        #1;
        r_valid = 1'b0;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80 || flush !== 1'b1) begin
            n_fail++;
            $display("FAIL same_new: taken=%b tgt=%h flush=%b want 1/80/1",
                     pred_taken, pred_target, flush);
        end
    endtask

    task automatic test_wrap();
        f_pc = 32'hFFFF_FFFC;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_pred: taken=%b tgt=%h want 0/0", pred_taken, pred_target);
        end
        resolve(32'hFFFF_FFFC, 3'd0, 1'b0, 32'h10, 1'b0, 32'h0);
        n_checks++;
        if (flush !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_nt: flush=%b want 0", flush);
        end
        // Taken to 0 equals the wrapped fall-through: allocate, no flush
        resolve(32'hFFFF_FFFC, 3'd0, 1'b1, 32'h0, 1'b0, 32'h0);
        n_checks++;
        if (flush !== 1'b0 || pred_taken !== 1'b1 || pred_target !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_tk: flush=%b taken=%b tgt=%h want 0/1/0",
                     flush, pred_taken, pred_target);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc;
        logic [31:0] tg;
        logic [31:0] ptg;
        logic [2:0]  ty;
        logic        tk;
        logic        ptk;
        int          bad;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            pc  = 32'h1000 + 32'(4 * $urandom_range(0, 31));
            ty  = 3'($urandom_range(0, 7));
            tk  = 1'($urandom);
            tg  = 32'h2000 + 32'(4 * $urandom_range(0, 15));
            ptk = 1'($urandom);
            ptg = ($urandom_range(0, 1) == 1) ? tg : pc + 32'd8;
            resolve(pc, ty, tk, tg, ptk, ptg);
            if (flush !== last_mis) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL rand_flush%0d: flush=%b want %b", k, flush, last_mis);
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rand_flush_total: %0d wrong pulses want 0", bad);
        end
        n_checks++;
        if (br_count !== exp_br) begin
            n_fail++;
            $display("FAIL rand_br_count: got %0d want %0d", br_count, exp_br);
        end
        n_checks++;
        if (mispred_count !== exp_mis) begin
            n_fail++;
            $display("FAIL rand_mis_count: got %0d want %0d", mispred_count, exp_mis);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        exp_br        = 32'd0;
        exp_mis       = 32'd0;
        last_mis      = 1'b0;
        rst           = 1'b1;
        f_pc          = 32'h0;
        r_valid       = 1'b0;
        r_pc          = 32'h0;
        r_br_type     = 3'd2;
        r_br_taken    = 1'b0;
        r_target      = 32'h0;
        r_pred_taken  = 1'b0;
        r_pred_target = 32'h0;
        test_reset();
        test_cold_loop();
        test_saturation();
        test_jal();
        test_alias();
        test_same_cycle();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
